ifetch_ctrl: RTL and testbench

- Instruction-fetch sequencer in front of the instruction decoder.
- Owns the PC and drives the instruction-memory port (mem_addr_I / mem_ren_I) under a stall handshake.
- Latches each returned word into an instruction register (IR) that feeds the decoder's mem_rdata_I input.
- Holds the IR until the execute stage accepts it; applies branch/jump redirects, including redirects that arrive while a fetch is outstanding.

---
 rtl/ifetch_ctrl_pkg.sv | 32 +++
 rtl/ifetch_ctrl_pc_sel.sv | 38 +++
 rtl/ifetch_ctrl.sv | 117 +++++++++++
 tb/tb_ifetch_ctrl.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_ctrl_pkg.sv
// ifetch_ctrl_pkg
//   Shared definitions for the instruction-fetch sequencer and the
//   execute-side redirect logic: FSM state encoding, reset PC default,
//   instruction width, and the base-ISA major opcodes the decoder uses.
package ifetch_ctrl_pkg;

  localparam int INSTR_W = 32;
  localparam int XLEN    = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch FSM encoding (kept as plain constants for legacy tools).
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;

  // Major opcodes (instr[6:0]) shared with the decoder.
  typedef logic [6:0] opcode_t;
  localparam opcode_t OPC_JAL    = 7'b110_1111;
  localparam opcode_t OPC_JALR   = 7'b110_0111;
  localparam opcode_t OPC_BRANCH = 7'b110_0011;
  localparam opcode_t OPC_LOAD   = 7'b000_0011;
  localparam opcode_t OPC_STORE  = 7'b010_0011;
  localparam opcode_t OPC_OP_IMM = 7'b001_0011;
  localparam opcode_t OPC_OP     = 7'b011_0011;

  // A fetch target is legal only on a 4-byte boundary.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_ctrl_pc_sel.sv
// ifetch_ctrl_pc_sel
//   Combinational next-PC selection for the fetch sequencer.
//   Ports:
//     pc          in   current PC
//     redirect    in   redirect pulse this cycle
//     redirect_pc in   redirect target
//     pend_valid  in   an earlier redirect target is waiting
//     pend_pc     in   that waiting target
//     next_pc     out  redirect_pc, else pend_pc, else pc+4 (wraps)
//     misaligned  out  redirect asserted with a non-word-aligned target
module ifetch_ctrl_pc_sel
  import ifetch_ctrl_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            pend_valid,
  input  logic [PC_W-1:0] pend_pc,
  output logic [PC_W-1:0] next_pc,
  output logic            misaligned
);

  logic [PC_W-1:0] seq_pc;

  // Unsigned add: the carry out of bit PC_W-1 is simply dropped, so the
  // last word of the address space wraps to 0.
  assign seq_pc = pc + PC_W'(4);

  // A redirect arriving this cycle always beats an older pending target.
  assign next_pc = redirect   ? redirect_pc :
                   pend_valid ? pend_pc     :
                                seq_pc;

  assign misaligned = redirect && !is_word_aligned(redirect_pc[1:0]);

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl
//   Instruction-fetch sequencer. Owns the PC, issues one instruction-memory
//   read at a time, latches the returned word into the IR for the decoder,
//   and holds it until execute consumes it. Handles branch/jump redirects,
//   including ones that land while a read is still stalled.
//   Ports:
//     clk, rst_n              clock / async active-low reset
//     mem_ren_I, mem_addr_I   read request and word address (pc[31:2])
//     mem_rdata_I             returned instruction word
//     mem_stall_I             memory busy; data valid when not stalled
//     ir, ir_pc, ir_valid     instruction register, its PC, valid flag
//     ex_ready                execute consumes ir this cycle
//     redirect, redirect_pc   one-cycle redirect pulse and its target
//     fetch_err               sticky misaligned-redirect error
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          PC_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               mem_ren_I,
  output logic [PC_W-3:0]    mem_addr_I,
  input  logic [INSTR_W-1:0] mem_rdata_I,
  input  logic               mem_stall_I,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    ir_pc,
  output logic               ir_valid,
  input  logic               ex_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               fetch_err
);

  logic [1:0]      state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pend_pc;
  // In FETCH this is the flush flag (discard the outstanding word); in HOLD
  // it marks a redirect target waiting for execute to consume the IR.
  logic            flush;

  logic [PC_W-1:0] next_pc;
  logic            misaligned;

  ifetch_ctrl_pc_sel #(.PC_W(PC_W)) u_pc_sel (
    .pc          (pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pend_valid  (flush),
    .pend_pc     (pend_pc),
    .next_pc     (next_pc),
    .misaligned  (misaligned)
  );

  // State is FETCH during reset, so the request is gated by rst_n directly.
  assign mem_ren_I  = rst_n && (state == ST_FETCH);
  assign mem_addr_I = pc[PC_W-1:2];
  assign ir_valid   = (state == ST_HOLD);
  assign fetch_err  = (state == ST_ERR);

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_FETCH;
      pc      <= PC_W'(RESET_PC);
      pend_pc <= '0;
      flush   <= 1'b0;
      ir      <= '0;
      ir_pc   <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (misaligned) begin
            state <= ST_ERR;
            flush <= 1'b0;
          end else if (!mem_stall_I) begin
            if (flush || redirect) begin
              // Completed word belongs to the old path: drop it and refetch.
              pc    <= next_pc;
              flush <= 1'b0;
            end else begin
              ir    <= mem_rdata_I;
              ir_pc <= pc;
              state <= ST_HOLD;
            end
          end else if (redirect) begin
            // Request cannot be aborted; remember where to go once it ends.
            flush   <= 1'b1;
            pend_pc <= redirect_pc;
          end
        end

        ST_HOLD: begin
          if (misaligned) begin
            state <= ST_ERR;
            flush <= 1'b0;
          end else if (ex_ready) begin
            pc    <= next_pc;
            flush <= 1'b0;
            state <= ST_FETCH;
          end else if (redirect) begin
            flush   <= 1'b1;
            pend_pc <= redirect_pc;
          end
        end

        default: begin
          // ST_ERR (and any illegal encoding) parks until reset.
          state <= ST_ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl
//   Self-checking bench for ifetch_ctrl. A behavioural memory returns a
//   word derived from its address; expected (ir_pc) values are queued as
//   fetches are set up and popped by a monitor whenever execute consumes ir.
module tb_ifetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_ren_I;
  logic [29:0] mem_addr_I;
  logic [31:0] mem_rdata_I;
  logic        mem_stall_I;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ex_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];

  ifetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_ren_I   (mem_ren_I),
    .mem_addr_I  (mem_addr_I),
    .mem_rdata_I (mem_rdata_I),
    .mem_stall_I (mem_stall_I),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ex_ready    (ex_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b11} ^ 32'hA5A5_0000;
  endfunction

  assign mem_rdata_I = mem_word(mem_addr_I);

  // Scoreboard: every consumed instruction must match the next queued PC.
  always @(negedge clk) begin
    if (rst_n && ir_valid && ex_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected: got ir_pc %h, required no instruction", ir_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (ir_pc !== e || ir !== mem_word(e[31:2])) begin
          tests_failed++;
          $display("FAIL sb_consume: got ir_pc %h ir %h, required ir_pc %h ir %h",
                   ir_pc, ir, e, mem_word(e[31:2]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    redirect = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    ex_ready = 1'b0;
    rst_n    = 1'b0;
    tick();
    tests_run++;
    if (mem_ren_I !== 1'b0 || ir_valid !== 1'b0 || fetch_err !== 1'b0 ||
        ir !== 32'h0 || ir_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_values: got ren %b valid %b err %b ir %h ir_pc %h, required all 0",
               mem_ren_I, ir_valid, fetch_err, ir, ir_pc);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (mem_ren_I !== 1'b1 || mem_addr_I !== 30'h0) begin
      tests_failed++;
      $display("FAIL first_request: got ren %b addr %h, required 1 / 0", mem_ren_I, mem_addr_I);
    end
    tick();
    tests_run++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'h0 || ir !== mem_word(30'h0)) begin
      tests_failed++;
      $display("FAIL first_valid_cycle2: got valid %b ir_pc %h ir %h, required 1 / 0 / %h",
               ir_valid, ir_pc, ir, mem_word(30'h0));
    end
  endtask

  task automatic test_sequential();
    ex_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'(4 * i));
      tests_run++;
      if (mem_ren_I !== 1'b1 || mem_addr_I !== 30'(i)) begin
        tests_failed++;
        $display("FAIL seq_addr: got ren %b addr %h, required 1 / %h", mem_ren_I, mem_addr_I, 30'(i));
      end
      tick();
      tests_run++;
      if (ir_valid !== 1'b1 || ir_pc !== 32'(4 * i) || mem_ren_I !== 1'b0) begin
        tests_failed++;
        $display("FAIL seq_ir: got valid %b ir_pc %h ren %b, required 1 / %h / 0",
                 ir_valid, ir_pc, mem_ren_I, 32'(4 * i));
      end
      tick();
    end
    ex_ready = 1'b0;
  endtask

  task automatic test_stall();
    ex_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'(4 * i));
      tick();
      tick();
    end
    mem_stall_I = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (mem_addr_I !== 30'h4 || mem_ren_I !== 1'b1 || ir_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold: got addr %h ren %b valid %b, required 4 / 1 / 0",
                 mem_addr_I, mem_ren_I, ir_valid);
      end
      tick();
    end
    mem_stall_I = 1'b0;
    exp_q.push_back(32'h10);
    tests_run++;
    if (mem_addr_I !== 30'h4 || ir_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_last: got addr %h valid %b, required 4 / 0", mem_addr_I, ir_valid);
    end
    tick();
    tests_run++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'h10) begin
      tests_failed++;
      $display("FAIL stall_capture: got valid %b ir_pc %h, required 1 / 10", ir_valid, ir_pc);
    end
    tick();
    ex_ready = 1'b0;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL stall_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_hold();
    ex_ready = 1'b0;
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (ir_valid !== 1'b1 || ir_pc !== 32'h0 || ir !== mem_word(30'h0) || mem_ren_I !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_stable: got valid %b ir_pc %h ir %h ren %b, required 1 / 0 / %h / 0",
                 ir_valid, ir_pc, ir, mem_ren_I, mem_word(30'h0));
      end
      tick();
    end
    exp_q.push_back(32'h0);
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
    tests_run++;
    if (mem_ren_I !== 1'b1 || mem_addr_I !== 30'h1) begin
      tests_failed++;
      $display("FAIL hold_next: got ren %b addr %h, required 1 / 1", mem_ren_I, mem_addr_I);
    end
  endtask

  task automatic test_redirect();
    ex_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(32'(4 * i));
      tick();
      tick();
    end
    // Redirect while the fetch of 0x8 is stalled.
    mem_stall_I = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    tests_run++;
    if (mem_addr_I !== 30'h2 || mem_ren_I !== 1'b1 || ir_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_keep_req: got addr %h ren %b valid %b, required 2 / 1 / 0",
               mem_addr_I, mem_ren_I, ir_valid);
    end
    tick();
    mem_stall_I = 1'b0;
    tick();
    tests_run++;
    if (ir_valid !== 1'b0 || mem_ren_I !== 1'b1 || mem_addr_I !== 30'h40) begin
      tests_failed++;
      $display("FAIL flush_discard: got valid %b ren %b addr %h, required 0 / 1 / 40",
               ir_valid, mem_ren_I, mem_addr_I);
    end
    exp_q.push_back(32'h100);
    tick();
    tests_run++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'h100) begin
      tests_failed++;
      $display("FAIL flush_target: got valid %b ir_pc %h, required 1 / 100", ir_valid, ir_pc);
    end
    tick();
    // Redirect on the same cycle the fetch of 0x104 completes.
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    tests_run++;
    if (ir_valid !== 1'b0 || mem_addr_I !== 30'h80) begin
      tests_failed++;
      $display("FAIL same_cycle_redirect: got valid %b addr %h, required 0 / 80", ir_valid, mem_addr_I);
    end
    ex_ready = 1'b0;
    tick();
    // Two redirects while held; the later one wins on consume.
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h400;
    tick();
    redirect = 1'b0;
    tests_run++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'h200) begin
      tests_failed++;
      $display("FAIL pending_hold: got valid %b ir_pc %h, required 1 / 200", ir_valid, ir_pc);
    end
    exp_q.push_back(32'h200);
    ex_ready = 1'b1;
    tick();
    tests_run++;
    if (mem_ren_I !== 1'b1 || mem_addr_I !== 30'h100) begin
      tests_failed++;
      $display("FAIL pending_overwrite: got ren %b addr %h, required 1 / 100", mem_ren_I, mem_addr_I);
    end
    exp_q.push_back(32'h400);
    tick();
    // Redirect together with consume overrides pc+4.
    redirect    = 1'b1;
    redirect_pc = 32'h500;
    tick();
    redirect = 1'b0;
    ex_ready = 1'b0;
    tests_run++;
    if (mem_ren_I !== 1'b1 || mem_addr_I !== 30'h140) begin
      tests_failed++;
      $display("FAIL consume_redirect: got ren %b addr %h, required 1 / 140", mem_ren_I, mem_addr_I);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL redirect_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_misaligned();
    ex_ready = 1'b0;
    do_reset();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
    tests_run++;
    if (fetch_err !== 1'b1 || ir_valid !== 1'b0 || mem_ren_I !== 1'b0) begin
      tests_failed++;
      $display("FAIL misalign_err: got err %b valid %b ren %b, required 1 / 0 / 0",
               fetch_err, ir_valid, mem_ren_I);
    end
    ex_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (fetch_err !== 1'b1 || mem_ren_I !== 1'b0) begin
        tests_failed++;
        $display("FAIL misalign_sticky: got err %b ren %b, required 1 / 0", fetch_err, mem_ren_I);
      end
    end
    ex_ready = 1'b0;
    rst_n    = 1'b0;
    #1;
    tests_run++;
    if (fetch_err !== 1'b0 || mem_ren_I !== 1'b0) begin
      tests_failed++;
      $display("FAIL misalign_reset: got err %b ren %b, required 0 / 0", fetch_err, mem_ren_I);
    end
    tick();
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (mem_ren_I !== 1'b1 || mem_addr_I !== 30'h0) begin
      tests_failed++;
      $display("FAIL misalign_restart: got ren %b addr %h, required 1 / 0", mem_ren_I, mem_addr_I);
    end
  endtask

  task automatic test_wrap();
    ex_ready = 1'b1;
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tests_run++;
    if (mem_addr_I !== 30'h3FFF_FFFF || ir_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_top: got addr %h valid %b, required 3fffffff / 0", mem_addr_I, ir_valid);
    end
    exp_q.push_back(32'hFFFF_FFFC);
    tick();
    tests_run++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL wrap_capture: got valid %b ir_pc %h, required 1 / fffffffc", ir_valid, ir_pc);
    end
    tick();
    tests_run++;
    if (mem_ren_I !== 1'b1 || mem_addr_I !== 30'h0) begin
      tests_failed++;
      $display("FAIL wrap_addr: got ren %b addr %h, required 1 / 0", mem_ren_I, mem_addr_I);
    end
    exp_q.push_back(32'h0);
    tick();
    tests_run++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_ir_pc: got valid %b ir_pc %h, required 1 / 0", ir_valid, ir_pc);
    end
    tick();
    ex_ready = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    ex_ready = 1'b1;
    do_reset();
    exp_q.push_back(32'h0);
    tick();
    tick();
    mem_stall_I = 1'b1;
    tick();
    ex_ready = 1'b0;
    rst_n    = 1'b0;
    #1;
    tests_run++;
    if (ir !== 32'h0 || ir_pc !== 32'h0 || ir_valid !== 1'b0 || mem_ren_I !== 1'b0) begin
      tests_failed++;
      $display("FAIL midfetch_reset: got ir %h ir_pc %h valid %b ren %b, required 0 / 0 / 0 / 0",
               ir, ir_pc, ir_valid, mem_ren_I);
    end
    mem_stall_I = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (mem_ren_I !== 1'b1 || mem_addr_I !== 30'h0) begin
      tests_failed++;
      $display("FAIL midfetch_restart: got ren %b addr %h, required 1 / 0", mem_ren_I, mem_addr_I);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    mem_stall_I = 1'b0;
    ex_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_hold();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
